// File: rtl/user_au_hpf_ctrl_pkg.sv
// rtl/user_au_hpf_ctrl_pkg.sv - register map, bit positions, FSM states and OBI types for the HPF coefficient controller
package user_au_hpf_ctrl_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } user_obi_a_chan_t;

  typedef struct packed {
    user_obi_a_chan_t a;
    logic             req;
  } user_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
    logic        r_optional;
  } user_obi_r_chan_t;

  typedef struct packed {
    logic             gnt;
    logic             rvalid;
    user_obi_r_chan_t r;
  } user_obi_rsp_t;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_TARGET  = 3'd1;
  localparam logic [2:0] REG_STEP    = 3'd2;
  localparam logic [2:0] REG_CURRENT = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_BYPASS = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  localparam int unsigned STATUS_BUSY = 0;
  localparam int unsigned STATUS_DONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } state_e;

  // Merge a 32-bit write into an existing value honouring byte enables.
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/user_au_hpf_ramp_step.sv
// rtl/user_au_hpf_ramp_step.sv - combinational one-step move of the coefficient toward its target
module user_au_hpf_ramp_step #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] current,
  input  logic [Width-1:0] target,
  input  logic [Width-1:0] step,
  output logic [Width-1:0] next,
  output logic             reached
);

  logic signed [Width:0] diff;
  logic        [Width:0] mag;

  // Difference carried in one extra bit so full-span jumps never wrap; a step of
  // zero means "jump straight to target".
  always_comb begin
    diff    = $signed({target[Width-1], target}) - $signed({current[Width-1], current});
    mag     = diff[Width] ? (~diff + 1'b1) : diff;
    reached = (step == '0) || (mag <= {1'b0, step});
    if (reached) begin
      next = target;
    end else if (diff[Width]) begin
      next = current - step;
    end else begin
      next = current + step;
    end
  end

endmodule

// File: rtl/user_au_hpf_ctrl.sv
// rtl/user_au_hpf_ctrl.sv - OBI-programmed click-free decay coefficient ramp for the HPF cascade (option: USER_AU_HPF_CTRL_IRQ_EN)
module user_au_hpf_ctrl
  import user_au_hpf_ctrl_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg     = ObiDefaultConfig,
  parameter type         obi_req_t  = user_obi_req_t,
  parameter type         obi_rsp_t  = user_obi_rsp_t,
  parameter int unsigned DecayWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  obi_req_t              obi_req_i,
  output obi_rsp_t              obi_rsp_o,
  input  logic                  sample_tick_i,
  output logic [DecayWidth-1:0] decay_o,
  output logic                  bypass_o,
  output logic                  busy_o,
  output logic                  irq_o
);

  localparam int unsigned DataWidth = ObiCfg.DataWidth;

  logic [2:0]  reg_idx;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        wr_en;
  logic        unused_addr_bits;

  assign reg_idx          = obi_req_i.a.addr[4:2];
  assign wdata            = obi_req_i.a.wdata;
  assign be               = obi_req_i.a.be;
  assign wr_en            = obi_req_i.req && obi_req_i.a.we;
  assign unused_addr_bits = ^{obi_req_i.a.addr[31:5], obi_req_i.a.addr[1:0]};

  logic                  enable_q;
  logic                  bypass_q;
  logic                  irq_en;
  logic [DecayWidth-1:0] target_q;
  logic [DecayWidth-1:0] step_q;
  logic [DecayWidth-1:0] current_q;
  logic                  done_q;
  state_e                state_q;
  state_e                state_d;

  logic wr_ctrl, wr_target, wr_step, wr_status;
  logic ctrl_enable_new, ctrl_bypass_new, ctrl_irq_en_new;
  logic en_rise, dis_wr, start, done_clr;
  logic cur_upd, set_done;

  logic [31:0] ctrl_val, status_val;
  logic [31:0] target_ext, step_ext, current_ext;
  logic [31:0] target_new, step_new;

  logic [DecayWidth-1:0] ramp_next;
  logic                  ramp_reached;

  assign wr_ctrl   = wr_en && (reg_idx == REG_CTRL);
  assign wr_target = wr_en && (reg_idx == REG_TARGET);
  assign wr_step   = wr_en && (reg_idx == REG_STEP);
  assign wr_status = wr_en && (reg_idx == REG_STATUS);

  assign target_ext  = 32'($signed(target_q));
  assign step_ext    = 32'(step_q);
  assign current_ext = 32'($signed(current_q));
  assign target_new  = apply_be(target_ext, wdata, be);
  assign step_new    = apply_be(step_ext, wdata, be);

  // CTRL lives entirely in byte 0, so only be[0] gates it.
  assign ctrl_enable_new = be[0] ? wdata[CTRL_ENABLE] : enable_q;
  assign ctrl_bypass_new = be[0] ? wdata[CTRL_BYPASS] : bypass_q;
  assign ctrl_irq_en_new = be[0] ? wdata[CTRL_IRQ_EN] : irq_en;

  assign en_rise  = wr_ctrl && ctrl_enable_new && !enable_q;
  assign dis_wr   = wr_ctrl && !ctrl_enable_new;
  assign start    = (wr_target && enable_q) || (en_rise && (target_q != current_q));
  assign done_clr = wr_status && be[0] && wdata[STATUS_DONE];

  user_au_hpf_ramp_step #(
    .Width(DecayWidth)
  ) u_ramp_step (
    .current(current_q),
    .target (target_q),
    .step   (step_q),
    .next   (ramp_next),
    .reached(ramp_reached)
  );

  // Ramp FSM next state: ticks use the registers as they stand before any
  // same-cycle write, and a retarget in the final-tick cycle keeps the ramp alive.
  always_comb begin
    state_d  = state_q;
    cur_upd  = 1'b0;
    set_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RAMP;
      end
      RAMP: begin
        if (dis_wr) begin
          state_d = IDLE;
        end else if (sample_tick_i) begin
          cur_upd = 1'b1;
          if (ramp_reached && !wr_target) state_d = DONE;
        end
      end
      DONE: begin
        set_done = 1'b1;
        state_d  = start ? RAMP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and programmable registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      enable_q  <= 1'b0;
      bypass_q  <= 1'b0;
      target_q  <= '0;
      step_q    <= '0;
      current_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_ctrl) begin
        enable_q <= ctrl_enable_new;
        bypass_q <= ctrl_bypass_new;
      end
      if (wr_target) target_q <= target_new[DecayWidth-1:0];
      if (wr_step) step_q <= step_new[DecayWidth-1:0];
      if (cur_upd) current_q <= ramp_next;
      done_q <= set_done || (done_q && !done_clr);
    end
  end

`ifdef USER_AU_HPF_CTRL_IRQ_EN
  logic irq_en_q;

  // Interrupt enable bit, present only in the irq-capable build.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_en_q <= 1'b0;
    end else if (wr_ctrl) begin
      irq_en_q <= ctrl_irq_en_new;
    end
  end

  assign irq_en = irq_en_q;
  assign irq_o  = (state_q == DONE) && irq_en_q;
`else
  logic unused_irq_en_new;

  assign unused_irq_en_new = ctrl_irq_en_new;
  assign irq_en            = 1'b0;
  assign irq_o             = 1'b0;
`endif

  assign decay_o  = current_q;
  assign bypass_o = bypass_q;
  assign busy_o   = (state_q == RAMP);

  logic [DataWidth-1:0] rdata_d, rdata_q;
  logic [31:0]          rd_val;
  logic                 err_d, err_q;
  logic                 rvalid_q;
  logic [3:0]           rid_q;

  // Read mux and error decode for the access being granted this cycle.
  always_comb begin
    ctrl_val                = '0;
    ctrl_val[CTRL_ENABLE]   = enable_q;
    ctrl_val[CTRL_BYPASS]   = bypass_q;
    ctrl_val[CTRL_IRQ_EN]   = irq_en;
    status_val              = '0;
    status_val[STATUS_BUSY] = busy_o;
    status_val[STATUS_DONE] = done_q;
    rd_val                  = '0;
    err_d                   = 1'b0;
    unique case (reg_idx)
      REG_CTRL:    rd_val = ctrl_val;
      REG_TARGET:  rd_val = target_ext;
      REG_STEP:    rd_val = step_ext;
      REG_CURRENT: begin
        rd_val = current_ext;
        err_d  = obi_req_i.a.we;
      end
      REG_STATUS:  rd_val = status_val;
      default:     err_d = 1'b1;
    endcase
    rdata_d = (obi_req_i.a.we || err_d) ? '0 : rd_val;
  end

  // Response channel registered one cycle after the grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= obi_req_i.req;
      if (obi_req_i.req) begin
        rid_q   <= obi_req_i.a.aid;
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  // Grant is immediate; every request is accepted.
  always_comb begin
    obi_rsp_o              = '0;
    obi_rsp_o.gnt          = obi_req_i.req;
    obi_rsp_o.rvalid       = rvalid_q;
    obi_rsp_o.r.rdata      = rdata_q;
    obi_rsp_o.r.rid        = rid_q;
    obi_rsp_o.r.err        = err_q;
    obi_rsp_o.r.r_optional = 1'b0;
  end

endmodule

// File: tb/tb_user_au_hpf_ctrl.sv
// tb/tb_user_au_hpf_ctrl.sv - scoreboard bench for the HPF coefficient controller
module tb_user_au_hpf_ctrl;
  import user_au_hpf_ctrl_pkg::*;

`ifdef USER_AU_HPF_CTRL_IRQ_EN
  localparam logic IrqBuilt = 1'b1;
`else
  localparam logic IrqBuilt = 1'b0;
`endif

  logic          clk;
  logic          rst;
  user_obi_req_t obi_req;
  user_obi_rsp_t obi_rsp;
  logic          sample_tick;
  logic [31:0]   decay;
  logic          bypass;
  logic          busy;
  logic          irq;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } rsp_exp_t;

  rsp_exp_t exp_q[$];
  int       n_checks = 0;
  int       n_errors = 0;
  int       irq_cnt  = 0;
  logic [3:0] aid_cnt = '0;

  user_au_hpf_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .obi_req_i    (obi_req),
    .obi_rsp_o    (obi_rsp),
    .sample_tick_i(sample_tick),
    .decay_o      (decay),
    .bypass_o     (bypass),
    .busy_o       (busy),
    .irq_o        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Response monitor: rvalid must follow each grant by exactly one cycle.
  always @(posedge clk) begin
    logic     fired;
    rsp_exp_t e;
    fired = obi_req.req && obi_rsp.gnt;
    #1;
    check_eq("rvalid_timing", 32'(obi_rsp.rvalid), 32'(fired));
    if (obi_rsp.rvalid) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_pending", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq({e.tag, "_rdata"}, obi_rsp.r.rdata, e.rdata);
        check_eq({e.tag, "_err"}, 32'(obi_rsp.r.err), 32'(e.err));
        check_eq({e.tag, "_rid"}, 32'(obi_rsp.r.rid), 32'(e.rid));
      end
    end
  end

  // Count irq pulses.
  always @(negedge clk) begin
    if (irq) irq_cnt++;
  end

  task automatic obi(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    rsp_exp_t e;
    obi_req.req     = 1'b1;
    obi_req.a.we    = we;
    obi_req.a.addr  = addr;
    obi_req.a.wdata = wdata;
    obi_req.a.be    = 4'hF;
    obi_req.a.aid   = aid_cnt;
    e.tag   = tag;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.rid   = aid_cnt;
    exp_q.push_back(e);
    aid_cnt++;
    @(negedge clk);
    obi_req.req  = 1'b0;
    obi_req.a.we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] data, input string tag);
    obi(1'b1, {27'd0, idx, 2'b00}, data, 32'd0, 1'b0, tag);
  endtask

  task automatic rd(input logic [2:0] idx, input logic [31:0] exp, input string tag);
    obi(1'b0, {27'd0, idx, 2'b00}, 32'd0, exp, 1'b0, tag);
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int irq_before;
    obi_req     = '0;
    sample_tick = 1'b0;
    rst         = 1'b1;
    cycles(3);
    check_eq("rst_decay", decay, 32'd0);
    check_eq("rst_bypass", 32'(bypass), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    rd(REG_STATUS, 32'd0, "rst_status");
    rd(REG_CTRL, 32'd0, "rst_ctrl");

    // Basic ramp
    wr(REG_STEP, 32'h100, "b_step");
    wr(REG_CTRL, 32'h5, "b_ctrl");
    wr(REG_TARGET, 32'h400, "b_target");
    check_eq("b_busy", 32'(busy), 32'd1);
    irq_before = irq_cnt;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq($sformatf("b_decay%0d", i), decay, 32'(i * 32'h100));
    end
    check_eq("b_irq_pulse", 32'(irq), 32'(IrqBuilt));
    cycles(1);
    check_eq("b_busy_end", 32'(busy), 32'd0);
    check_eq("b_irq_gone", 32'(irq), 32'd0);
    check_eq("b_irq_count", 32'(irq_cnt - irq_before), 32'(IrqBuilt));
    rd(REG_STATUS, 32'h2, "b_status");
    wr(REG_STATUS, 32'h2, "b_w1c");
    rd(REG_STATUS, 32'h0, "b_status_clr");

    // Negative ramp with clamp
    wr(REG_STEP, 32'h300, "n_step");
    wr(REG_TARGET, 32'hFFFF_FF00, "n_target");
    tick();
    check_eq("n_decay1", decay, 32'h100);
    tick();
    check_eq("n_decay2", decay, 32'hFFFF_FF00);
    cycles(1);
    rd(REG_CURRENT, 32'hFFFF_FF00, "n_current");

    // Extreme span with step 0
    wr(REG_STEP, 32'h0, "x_step");
    wr(REG_TARGET, 32'h8000_0000, "x_target_min");
    tick();
    check_eq("x_decay_min", decay, 32'h8000_0000);
    cycles(1);
    wr(REG_TARGET, 32'h7FFF_FFFF, "x_target_max");
    tick();
    check_eq("x_decay_max", decay, 32'h7FFF_FFFF);
    cycles(1);
    check_eq("x_busy_end", 32'(busy), 32'd0);

    // Abort and retarget
    wr(REG_TARGET, 32'h0, "a_target0");
    tick();
    cycles(1);
    wr(REG_STEP, 32'h100, "a_step");
    wr(REG_TARGET, 32'h400, "a_target");
    tick();
    tick();
    check_eq("a_decay_mid", decay, 32'h200);
    wr(REG_STATUS, 32'h2, "a_w1c");
    irq_before = irq_cnt;
    wr(REG_CTRL, 32'h4, "a_disable");
    check_eq("a_busy_off", 32'(busy), 32'd0);
    repeat (10) tick();
    check_eq("a_decay_hold", decay, 32'h200);
    check_eq("a_no_irq", 32'(irq_cnt - irq_before), 32'd0);
    rd(REG_STATUS, 32'h0, "a_status");
    wr(REG_CTRL, 32'h5, "a_enable");
    check_eq("a_busy_on", 32'(busy), 32'd1);
    wr(REG_TARGET, 32'h100, "a_retarget");
    check_eq("a_busy_stay", 32'(busy), 32'd1);
    tick();
    check_eq("a_decay_ret", decay, 32'h100);
    cycles(1);
    check_eq("a_busy_end", 32'(busy), 32'd0);

    // OBI errors and back-to-back timing
    obi(1'b0, 32'h14, 32'd0, 32'd0, 1'b1, "o_rd_bad");
    obi(1'b1, 32'h0C, 32'hDEAD, 32'd0, 1'b1, "o_wr_current");
    rd(REG_CURRENT, 32'h100, "o_current");
    wr(REG_STEP, 32'h55, "o_b2b_wr");
    rd(REG_STEP, 32'h55, "o_b2b_rd");
    obi(1'b0, 32'h1C, 32'd0, 32'd0, 1'b1, "o_rd_bad7");
    obi(1'b1, 32'h18, 32'h1, 32'd0, 1'b1, "o_wr_bad6");
    rd(REG_CTRL, IrqBuilt ? 32'h5 : 32'h1, "o_ctrl");
    wr(REG_CTRL, 32'h7, "o_bypass_on");
    check_eq("o_bypass", 32'(bypass), 32'd1);
    rd(REG_CTRL, IrqBuilt ? 32'h7 : 32'h3, "o_ctrl_byp");
    wr(REG_CTRL, 32'h5, "o_bypass_off");
    check_eq("o_bypass_off", 32'(bypass), 32'd0);

    // Reset mid-ramp
    wr(REG_STEP, 32'h10, "r_step");
    wr(REG_TARGET, 32'h200, "r_target");
    tick();
    check_eq("r_decay_pre", decay, 32'h110);
    irq_before = irq_cnt;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check_eq("r_decay", decay, 32'd0);
    check_eq("r_busy", 32'(busy), 32'd0);
    rd(REG_STATUS, 32'h0, "r_status");
    rd(REG_CTRL, 32'h0, "r_ctrl");
    cycles(3);
    check_eq("r_no_irq", 32'(irq_cnt - irq_before), 32'd0);

    cycles(2);
    check_eq("rsp_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
